fighter_motion: RTL and testbench

Parametrised per-player movement controller for the fighting-game core; one instance per fighter, clocked by the frame tick.
- Decodes the shared USB keycode slots into walk, crouch and jump.
- Runs an integrated jump/gravity state machine, so no external jump controller is needed.
- Applies knockback, enforces the stage bounds and the minimum gap to the opponent, and reports sprite position plus pose flags to the sprite/hitbox logic.

---
 rtl/fighter_pkg.sv | 32 +++
 rtl/key_match.sv | 21 ++
 rtl/fighter_motion.sv | 197 +++++++++++++++++++
 tb/tb_fighter_motion.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// Shared types and constants for the fighter movement controllers.
package fighter_pkg;

  typedef enum logic [1:0] {GROUND, CROUCH, AIR, LAND} state_e;

  // Stage geometry (sprite top-left coordinates)
  localparam int GROUND_Y = 170;
  localparam int X_MIN    = 10;
  localparam int X_MAX    = 629;

  // Player 1 controls: keypad-style codes
  localparam logic [7:0] P1_KEY_L = 8'h0d;
  localparam logic [7:0] P1_KEY_R = 8'h0f;
  localparam logic [7:0] P1_KEY_D = 8'h0e;
  localparam logic [7:0] P1_KEY_U = 8'h0c;

  // Player 2 controls: A / D / S / W
  localparam logic [7:0] P2_KEY_L = 8'h04;
  localparam logic [7:0] P2_KEY_R = 8'h07;
  localparam logic [7:0] P2_KEY_D = 8'h16;
  localparam logic [7:0] P2_KEY_U = 8'h1a;

  // Zero a walk step that heads toward the opponent while too close.
  function automatic logic signed [11:0] gap_gate(input logic signed [11:0] walk,
                                                  input logic face_left,
                                                  input logic blocked);
    logic fwd;
    fwd = face_left ? (walk < 12'sd0) : (walk > 12'sd0);
    return (fwd && blocked) ? 12'sd0 : walk;
  endfunction

endpackage

// File: rtl/key_match.sv
// Scans NUM_KEYS keycode slots and flags which of NUM_CODES codes are held.
module key_match #(
  parameter int unsigned NUM_KEYS  = 4,
  parameter int unsigned NUM_CODES = 4
) (
  input  logic [NUM_KEYS-1:0][7:0]  keycode,
  input  logic [NUM_CODES-1:0][7:0] codes,
  output logic [NUM_CODES-1:0]      hit
);

  // A code is held if any non-empty slot carries it
  always_comb begin
    hit = '0;
    for (int unsigned c = 0; c < NUM_CODES; c++) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (codes[c] != 8'h00 && keycode[k] == codes[c]) hit[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fighter_motion.sv
// Per-fighter movement controller: key decode, jump/gravity FSM, knockback,
// stage clamp and opponent gap. Optional air jump behind FIGHTER_DOUBLE_JUMP_EN.
module fighter_motion #(
  parameter int unsigned NUM_KEYS    = 4,
  parameter int          START_X     = 480,
  parameter int          GROUND_Y    = fighter_pkg::GROUND_Y,
  parameter int          X_MIN       = fighter_pkg::X_MIN,
  parameter int          X_MAX       = fighter_pkg::X_MAX,
  parameter int          SPRITE_W    = 125,
  parameter int          MIN_GAP     = 105,
  parameter bit          FACE_LEFT   = 1'b1,
  parameter int          WALK_SPEED  = 2,
  parameter int          JUMP_VEL    = 12,
  parameter int          GRAVITY     = 1,
  parameter int          LAND_FRAMES = 4,
  parameter logic [7:0]  KEY_L       = fighter_pkg::P1_KEY_L,
  parameter logic [7:0]  KEY_R       = fighter_pkg::P1_KEY_R,
  parameter logic [7:0]  KEY_D       = fighter_pkg::P1_KEY_D,
  parameter logic [7:0]  KEY_U       = fighter_pkg::P1_KEY_U
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic [NUM_KEYS-1:0][7:0] keycode,
  input  logic                     GamePlaying,
  input  logic signed [31:0]       XDist,
  input  logic signed [31:0]       Knockback,
  output logic [9:0]               PosX,
  output logic [9:0]               PosY,
  output logic                     Jumping,
  output logic                     Crouching,
  output logic                     MoveLeft,
  output logic                     MoveRight,
  output logic                     Landing
);

  import fighter_pkg::*;

  localparam logic signed [11:0] WALK_S = 12'(WALK_SPEED);
  localparam logic signed [11:0] JUMP_S = 12'(JUMP_VEL);
  localparam logic signed [11:0] GRAV_S = 12'(GRAVITY);
  localparam logic signed [11:0] Y_GND_S = 12'(GROUND_Y);
  localparam logic signed [11:0] X_LO_S = 12'(X_MIN);
  localparam logic signed [11:0] X_HI_S = 12'(X_MAX - SPRITE_W);

  logic [3:0] key_hit;
  logic       key_l, key_r, key_d, key_u;
  logic       gap_block;

  state_e             state_q, state_d;
  logic [9:0]         pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [11:0] vy_q, vy_d, air_vx_q, air_vx_d;
  logic [7:0]         lag_q, lag_d;
  logic               move_l_q, move_l_d, move_r_q, move_r_d;
  logic signed [11:0] key_walk, walk, kb_sat, x_sum, y_sum;

`ifdef FIGHTER_DOUBLE_JUMP_EN
  logic u_prev_q, air_jumps_q, air_jumps_d;
`endif

  key_match #(
    .NUM_KEYS  (NUM_KEYS),
    .NUM_CODES (4)
  ) u_key_match (
    .keycode (keycode),
    .codes   ({KEY_U, KEY_D, KEY_R, KEY_L}),
    .hit     (key_hit)
  );

  assign key_l     = key_hit[0];
  assign key_r     = key_hit[1];
  assign key_d     = key_hit[2];
  assign key_u     = key_hit[3];
  assign gap_block = (XDist <= MIN_GAP);

  // Saturate knockback so the 12-bit position sum can never wrap
  always_comb begin
    if (Knockback > 32'sd1023)       kb_sat = 12'sd1023;
    else if (Knockback < -32'sd1024) kb_sat = -12'sd1024;
    else                             kb_sat = Knockback[11:0];
  end

  // State register; reset lands the fighter on the ground at its start column
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= GROUND;
      pos_x_q     <= 10'(START_X);
      pos_y_q     <= 10'(GROUND_Y);
      vy_q        <= '0;
      air_vx_q    <= '0;
      lag_q       <= '0;
      move_l_q    <= 1'b0;
      move_r_q    <= 1'b0;
`ifdef FIGHTER_DOUBLE_JUMP_EN
      u_prev_q    <= 1'b0;
      air_jumps_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      vy_q        <= vy_d;
      air_vx_q    <= air_vx_d;
      lag_q       <= lag_d;
      move_l_q    <= move_l_d;
      move_r_q    <= move_r_d;
`ifdef FIGHTER_DOUBLE_JUMP_EN
      u_prev_q    <= key_u;
      air_jumps_q <= air_jumps_d;
`endif
    end
  end

  // Next-state: FSM transitions, vertical motion, then horizontal sum and clamp
  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    vy_d     = vy_q;
    air_vx_d = air_vx_q;
    lag_d    = lag_q;
    walk     = 12'sd0;
    x_sum    = 12'sd0;
    y_sum    = $signed({2'b00, pos_y_q}) + vy_q;
`ifdef FIGHTER_DOUBLE_JUMP_EN
    air_jumps_d = air_jumps_q;
`endif

    if (key_l && !key_r)      key_walk = -WALK_S;
    else if (key_r && !key_l) key_walk = WALK_S;
    else                      key_walk = 12'sd0;

    if (GamePlaying) begin
      unique case (state_q)
        GROUND: begin
          if (key_u) begin
            state_d  = AIR;
            vy_d     = -JUMP_S;
            air_vx_d = key_walk;  // drift speed is frozen for the whole jump
`ifdef FIGHTER_DOUBLE_JUMP_EN
            air_jumps_d = 1'b1;
`endif
          end else if (key_d) begin
            state_d = CROUCH;
          end else begin
            walk = gap_gate(key_walk, FACE_LEFT, gap_block);
          end
        end
        CROUCH: begin
          if (!key_d) state_d = GROUND;
        end
        AIR: begin
          walk = gap_gate(air_vx_q, FACE_LEFT, gap_block);
          if (y_sum >= Y_GND_S) begin
            pos_y_d = 10'(GROUND_Y);
            vy_d    = 12'sd0;
            state_d = LAND;
            lag_d   = 8'(LAND_FRAMES - 1);
          end else begin
            pos_y_d = 10'(y_sum);
            vy_d    = vy_q + GRAV_S;
`ifdef FIGHTER_DOUBLE_JUMP_EN
            if (key_u && !u_prev_q && air_jumps_q) begin
              vy_d        = -JUMP_S;
              air_jumps_d = 1'b0;
            end
`endif
          end
        end
        LAND: begin
          if (lag_q == 8'd0) state_d = GROUND;
          else               lag_d   = lag_q - 8'd1;
        end
        default: state_d = GROUND;
      endcase

      x_sum = $signed({2'b00, pos_x_q}) + walk + kb_sat;
      if (x_sum < X_LO_S)      pos_x_d = 10'(X_LO_S);
      else if (x_sum > X_HI_S) pos_x_d = 10'(X_HI_S);
      else                     pos_x_d = 10'(x_sum);
    end

    move_l_d = walk < 12'sd0;
    move_r_d = walk > 12'sd0;
  end

  // Outputs: position and pose flags straight from registered state
  always_comb begin
    PosX      = pos_x_q;
    PosY      = pos_y_q;
    Jumping   = (state_q == AIR);
    Crouching = (state_q == CROUCH);
    Landing   = (state_q == LAND);
    MoveLeft  = move_l_q;
    MoveRight = move_r_q;
  end

endmodule

// File: tb/tb_fighter_motion.sv
// Self-checking bench for fighter_motion with a trajectory-level reference model.
module tb_fighter_motion;

  localparam int START_X = 480;
  localparam int GND_Y   = 170;
  localparam int XLO     = 10;
  localparam int XHI     = 629 - 125;
  localparam int MIN_GAP = 105;
  localparam int WS      = 2;
  localparam int JV      = 12;
  localparam int GR      = 1;
  localparam int LANDF   = 4;
  localparam logic [7:0] KL = 8'h0d, KR = 8'h0f, KD = 8'h0e, KU = 8'h0c;

  localparam int MD_GROUND = 0, MD_CROUCH = 1, MD_AIR = 2, MD_LAND = 3;

  logic              frame_clk = 1'b0;
  logic              Reset = 1'b0;
  logic [3:0][7:0]   keycode = '0;
  logic              GamePlaying = 1'b1;
  logic signed [31:0] XDist = 200;
  logic signed [31:0] Knockback = 0;
  logic [9:0]        PosX, PosY;
  logic              Jumping, Crouching, MoveLeft, MoveRight, Landing;

  bit kl, kr, kd, ku;
  int rot = 0;
  int n_checks = 0;
  int n_errors = 0;
  int land_cnt;

  fighter_motion dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .GamePlaying (GamePlaying),
    .XDist       (XDist),
    .Knockback   (Knockback),
    .PosX        (PosX),
    .PosY        (PosY),
    .Jumping     (Jumping),
    .Crouching   (Crouching),
    .MoveLeft    (MoveLeft),
    .MoveRight   (MoveRight),
    .Landing     (Landing)
  );

  always #5 frame_clk = ~frame_clk;

  // Airborne height is computed in closed form from frames since the last impulse.
  typedef struct {
    int x; int y; int mode; int k; int ybase; int vx; int land_left;
    bit ml; bit mr; bit ajump; bit uprev;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.x = START_X; r.y = GND_Y; r.mode = MD_GROUND; r.k = 0; r.ybase = GND_Y;
    r.vx = 0; r.land_left = 0; r.ml = 0; r.mr = 0; r.ajump = 0; r.uprev = 0;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, bit l, bit r, bit d, bit u, bit play,
                                        int xdist, int kb);
    model_t n;
    int want, walk, cand;
    n = c;
    n.uprev = u;
    n.ml = 0;
    n.mr = 0;
    if (!play) return n;
    want = (l && !r) ? -WS : (r && !l) ? WS : 0;
    walk = 0;
    case (c.mode)
      MD_GROUND: begin
        if (u) begin
          n.mode = MD_AIR; n.k = 0; n.ybase = c.y; n.vx = want; n.ajump = 1;
        end else if (d) n.mode = MD_CROUCH;
        else walk = want;
      end
      MD_CROUCH: if (!d) n.mode = MD_GROUND;
      MD_AIR: begin
        walk = c.vx;
        n.k = c.k + 1;
        cand = c.ybase - JV * n.k + GR * n.k * (n.k - 1) / 2;
        if (cand >= GND_Y) begin
          n.y = GND_Y; n.mode = MD_LAND; n.land_left = LANDF;
        end else begin
          n.y = cand;
`ifdef FIGHTER_DOUBLE_JUMP_EN
          if (u && !c.uprev && c.ajump) begin
            n.ybase = cand; n.k = 0; n.ajump = 0;
          end
`endif
        end
      end
      default: begin
        n.land_left = c.land_left - 1;
        if (n.land_left == 0) n.mode = MD_GROUND;
      end
    endcase
    // forward is left for this fighter
    if (walk < 0 && xdist <= MIN_GAP) walk = 0;
    n.x = c.x + walk + kb;
    if (n.x < XLO) n.x = XLO;
    if (n.x > XHI) n.x = XHI;
    n.ml = walk < 0;
    n.mr = walk > 0;
    return n;
  endfunction

  // Reference model advances on the same edges as the DUT
  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) m <= model_reset();
    else       m <= model_next(m, kl, kr, kd, ku, GamePlaying, XDist, Knockback);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT against model, sampled mid-cycle
  always @(negedge frame_clk) begin
    check("PosX", int'(PosX), m.x);
    check("PosY", int'(PosY), m.y);
    check("Jumping", int'(Jumping), int'(m.mode == MD_AIR));
    check("Crouching", int'(Crouching), int'(m.mode == MD_CROUCH));
    check("Landing", int'(Landing), int'(m.mode == MD_LAND));
    check("MoveLeft", int'(MoveLeft), int'(m.ml));
    check("MoveRight", int'(MoveRight), int'(m.mr));
  end

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_keys(input bit l, input bit r, input bit d, input bit u);
    logic [3:0][7:0] kc;
    int n;
    kc = '0;
    n = 0;
    kl = l; kr = r; kd = d; ku = u;
    if (l) begin kc[(rot + n) % 4] = KL; n++; end
    if (r) begin kc[(rot + n) % 4] = KR; n++; end
    if (d) begin kc[(rot + n) % 4] = KD; n++; end
    if (u) begin kc[(rot + n) % 4] = KU; n++; end
    if (n < 4 && (rot % 2) == 1) kc[(rot + n) % 4] = 8'h2c;  // unrelated key in a spare slot
    keycode = kc;
    rot++;
  endtask

  function automatic int flags();
    return int'({Jumping, Crouching, Landing, MoveLeft, MoveRight});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    set_keys(0, 0, 0, 0);
    #1 Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    step();
    check("reset_posx", int'(PosX), 480);
    check("reset_posy", int'(PosY), 170);
    check("reset_flags", flags(), 0);

    // Single jump: takeoff, apex at AIR frame 12, touchdown at frame 25, 4 lag frames
    set_keys(0, 0, 0, 1);
    step();
    set_keys(0, 0, 0, 0);
    check("takeoff_jumping", int'(Jumping), 1);
    check("takeoff_posy", int'(PosY), 170);
    repeat (12) step();
    check("apex_posy", int'(PosY), 92);
    repeat (13) step();
    check("touchdown_posy", int'(PosY), 170);
    check("touchdown_landing", int'(Landing), 1);
    land_cnt = 1;
    repeat (4) begin
      step();
      if (Landing) land_cnt++;
    end
    check("landing_frames", land_cnt, 4);
    check("after_land_jumping", int'(Jumping), 0);

    // Motion disabled: nothing moves, no jump, move flags low
    GamePlaying = 1'b0;
    set_keys(1, 0, 0, 1);
    repeat (3) step();
    check("hold_posx", int'(PosX), 480);
    check("hold_flags", flags(), 0);
    GamePlaying = 1'b1;
    set_keys(0, 0, 0, 0);
    step();

    // Opponent gap: forward (left) blocked at XDist <= 105, backward never
    set_keys(1, 0, 0, 0);
    XDist = 106;
    step();
    check("gap106_posx", int'(PosX), 478);
    check("gap106_moveleft", int'(MoveLeft), 1);
    XDist = 105;
    step();
    check("gap105_posx", int'(PosX), 478);
    check("gap105_moveleft", int'(MoveLeft), 0);
    set_keys(0, 1, 0, 0);
    XDist = 50;
    step();
    check("back_posx", int'(PosX), 480);
    check("back_moveright", int'(MoveRight), 1);

    // Both directions cancel
    XDist = 200;
    set_keys(1, 1, 0, 0);
    step();
    check("lr_posx", int'(PosX), 480);
    check("lr_flags", flags(), 0);

    // Crouch ignores walk and jump keys
    set_keys(1, 0, 1, 0);
    step();
    check("crouch_flag", int'(Crouching), 1);
    check("crouch_posx", int'(PosX), 480);
    set_keys(0, 1, 1, 1);
    step();
    check("crouch_u_ignored", flags(), 5'b01000);
    set_keys(0, 0, 0, 0);
    step();
    check("uncrouch", int'(Crouching), 0);

    // Right clamp at 504 and left clamp at 10
    Knockback = 23;
    step();
    Knockback = 0;
    check("kb_posx", int'(PosX), 503);
    set_keys(0, 1, 0, 0);
    step();
    check("clamp_r1", int'(PosX), 504);
    step();
    check("clamp_r2", int'(PosX), 504);
    set_keys(0, 0, 0, 0);
    Knockback = -493;
    step();
    check("kb_to_11", int'(PosX), 11);
    Knockback = -3;
    step();
    check("clamp_l", int'(PosX), 10);
    Knockback = 0;

    // Drifting jump with air knockback, then async reset mid-air
    set_keys(0, 1, 0, 1);
    step();
    set_keys(0, 0, 0, 0);
    step(); step();
    Knockback = 5;
    step();
    Knockback = 0;
    step(); step();
    check("drift_posx", int'(PosX), 25);
    check("air5_posy", int'(PosY), 120);
    check("air5_jumping", int'(Jumping), 1);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_posx", int'(PosX), 480);
    check("async_reset_posy", int'(PosY), 170);
    check("async_reset_flags", flags(), 0);
    step();
    Reset = 1'b0;
    step();
    check("post_reset_posx", int'(PosX), 480);
    check("post_reset_posy", int'(PosY), 170);
    check("post_reset_flags", flags(), 0);

    // U re-pressed at AIR frame 5, again at frame 8
    set_keys(0, 0, 0, 1);
    step();
    set_keys(0, 0, 0, 0);
    repeat (4) step();
    set_keys(0, 0, 0, 1);
    step();
    check("dj_f5_posy", int'(PosY), 120);
    set_keys(0, 0, 0, 0);
    step();
`ifdef FIGHTER_DOUBLE_JUMP_EN
    check("dj_f6_posy", int'(PosY), 108);
`else
    check("dj_f6_posy", int'(PosY), 113);
`endif
    step();
    set_keys(0, 0, 0, 1);
    step();
    set_keys(0, 0, 0, 0);
    repeat (40) step();
    check("dj_settled_posy", int'(PosY), 170);
    check("dj_settled_flags", flags(), 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
